// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
//
// Two-state (IDLE/EXEC) accumulator that uses an external combinational
// adder-subtractor. When an operand is accepted, the block registers the
// current accumulator and the operand on addsub_x/addsub_y, and the operation
// on addsub_add_n. One cycle later it takes the adder's result back into the
// accumulator.
//
// Parameters
//   n    operand/accumulator width (two's complement)
//   SAT  1 = clamp accumulator to signed max/min on overflow, 0 = wrap
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   clr               synchronous clear of accumulator, flags, counter, done
//   in_valid/in_ready operand handshake; in_ready = IDLE and not clr
//   in_data, in_sub   operand and operation (0 = add, 1 = subtract)
//   addsub_x/y/add_n  registered operands to the external adder-subtractor
//   addsub_s/c_out/over_flow  same-cycle result from that adder-subtractor
//   acc, carry        accumulator and carry-out of the last completed operation
//   ovf_sticky        set by any overflowing operation, cleared by clr/reset
//   done              one-cycle pulse after each completed operation
//   op_cnt            completed-operation count, saturating at 255
// -----------------------------------------------------------------------------
module addsub_accumulator #(
  parameter int n   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  input  logic         in_sub,
  output logic [n-1:0] addsub_x,
  output logic [n-1:0] addsub_y,
  output logic         addsub_add_n,
  input  logic [n-1:0] addsub_s,
  input  logic         addsub_c_out,
  input  logic         addsub_over_flow,
  output logic [n-1:0] acc,
  output logic         carry,
  output logic         ovf_sticky,
  output logic         done,
  output logic [7:0]   op_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t       state_r;
  logic [n-1:0] acc_r;
  logic [n-1:0] x_r;
  logic [n-1:0] y_r;
  logic         add_n_r;
  logic         carry_r;
  logic         ovf_r;
  logic         done_r;
  logic [7:0]   cnt_r;

  logic [n-1:0] acc_next_s;
  logic [7:0]   cnt_next_s;

  // Clamp value on signed overflow. Overflow can only move a value away from
  // the sign of the starting accumulator, so the sign of addsub_x picks the
  // rail: positive start -> 0111..1, negative start -> 1000..0.
  function automatic logic [n-1:0] sat_limit(input logic start_msb);
    return {start_msb, {(n-1){~start_msb}}};
  endfunction

  // Saturating increment of the operation counter.
  function automatic logic [7:0] cnt_inc(input logic [7:0] cnt);
    logic [7:0] res;
    if (cnt == 8'd255) begin
      res = cnt;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

  // Handshake is only offered in IDLE and never while a clear is pending.
  always_comb begin
    in_ready = (state_r == IDLE) && !clr;
  end

  // Value the accumulator takes when the current EXEC cycle completes.
  always_comb begin
    acc_next_s = addsub_s;
    if (SAT && addsub_over_flow) begin
      acc_next_s = sat_limit(addsub_x[n-1]);
    end else begin
      acc_next_s = addsub_s;
    end
    cnt_next_s = cnt_inc(cnt_r);
  end

  // Control FSM plus all datapath registers. clr outranks everything except
  // reset, so an operation sitting in EXEC is dropped without being counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {n{1'b0}};
      x_r     <= {n{1'b0}};
      y_r     <= {n{1'b0}};
      add_n_r <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= 8'd0;
    end else if (clr) begin
      // Operand registers keep their values; only result state is cleared.
      state_r <= IDLE;
      acc_r   <= {n{1'b0}};
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (in_valid && in_ready) begin
            x_r     <= acc_r;
            y_r     <= in_data;
            add_n_r <= in_sub;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // The adder result for x_r/y_r/add_n_r is valid during this cycle.
          acc_r   <= acc_next_s;
          carry_r <= addsub_c_out;
          ovf_r   <= ovf_r | addsub_over_flow;
          cnt_r   <= cnt_next_s;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered outputs.
  always_comb begin
    addsub_x     = x_r;
    addsub_y     = y_r;
    addsub_add_n = add_n_r;
    acc          = acc_r;
    carry        = carry_r;
    ovf_sticky   = ovf_r;
    done         = done_r;
    op_cnt       = cnt_r;
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
module tb_addsub_accumulator;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] acc;
    logic         carry;
    logic         ovf;
    logic [7:0]   cnt;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_sub;
  logic [N-1:0] in_data;

  // Index 0: wrapping instance, index 1: saturating instance.
  logic         rdy_o   [2];
  logic [N-1:0] x_o     [2];
  logic [N-1:0] y_o     [2];
  logic         an_o    [2];
  logic [N-1:0] s_i     [2];
  logic         c_i     [2];
  logic         o_i     [2];
  logic [N-1:0] acc_o   [2];
  logic         carry_o [2];
  logic         ovf_o   [2];
  logic         done_o  [2];
  logic [7:0]   cnt_o   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cnt = 0;
  bit hs_next  = 1'b0;
  bit clr_next = 1'b0;

  exp_t q [2][$];
  int   m_acc [2];
  bit   m_ovf [2];
  int   m_cnt;

  always #5 clk = ~clk;

  // External combinational adder-subtractor: {over_flow, c_out, s}.
  function automatic logic [N+1:0] ext_addsub(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic add_n);
    logic [N-1:0] yy;
    logic [N:0]   sum;
    logic         ov;
    yy  = add_n ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, add_n};
    ov  = (x[N-1] == yy[N-1]) && (sum[N-1] != x[N-1]);
    return {ov, sum};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ext
    assign {o_i[g], c_i[g], s_i[g]} = ext_addsub(x_o[g], y_o[g], an_o[g]);
  end

  addsub_accumulator #(.n(N), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_o[0]),
    .in_data(in_data), .in_sub(in_sub), .addsub_x(x_o[0]), .addsub_y(y_o[0]),
    .addsub_add_n(an_o[0]), .addsub_s(s_i[0]), .addsub_c_out(c_i[0]),
    .addsub_over_flow(o_i[0]), .acc(acc_o[0]), .carry(carry_o[0]),
    .ovf_sticky(ovf_o[0]), .done(done_o[0]), .op_cnt(cnt_o[0]));

  addsub_accumulator #(.n(N), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_o[1]),
    .in_data(in_data), .in_sub(in_sub), .addsub_x(x_o[1]), .addsub_y(y_o[1]),
    .addsub_add_n(an_o[1]), .addsub_s(s_i[1]), .addsub_c_out(c_i[1]),
    .addsub_over_flow(o_i[1]), .acc(acc_o[1]), .carry(carry_o[1]),
    .ovf_sticky(ovf_o[1]), .done(done_o[1]), .op_cnt(cnt_o[1]));

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: signed integer arithmetic on the accumulator value.
  function automatic void ref_op(input int a, input int du, input bit sub, input bit sat,
                                 output int r, output bit c, output bit o);
    int ds;
    int au;
    ds = (du >= 8) ? du - 16 : du;
    au = (a < 0) ? a + 16 : a;
    r  = sub ? a - ds : a + ds;
    o  = (r > 7) || (r < -8);
    c  = sub ? (au >= du) : (au + du > 15);
    if (o && sat)      r = (r > 7) ? 7 : -8;
    else if (o)        r = (r > 7) ? r - 16 : r + 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Scoreboard producer: applies the event seen just before this edge.
  always @(posedge clk) begin
    if (clr_next) begin
      model_reset();
    end else if (hs_next) begin
      hs_cnt++;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      for (int i = 0; i < 2; i++) begin
        int r;
        bit c;
        bit o;
        exp_t e;
        ref_op(m_acc[i], int'(in_data), in_sub, (i == 1), r, c, o);
        m_acc[i] = r;
        m_ovf[i] = m_ovf[i] | o;
        e.acc   = N'(r);
        e.carry = c;
        e.ovf   = m_ovf[i];
        e.cnt   = 8'(m_cnt);
        e.due   = cyc + 2;
        q[i].push_back(e);
      end
    end
    cyc++;
  end

  // Monitor: compares on every done pulse; also samples next-edge events.
  always @(negedge clk) begin
    hs_next  = rst_n && !clr && in_valid && rdy_o[0];
    clr_next = rst_n && clr;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (done_o[i]) begin
          if (q[i].size() == 0) begin
            chk("unexpected_done", int'(done_o[i]), 0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk("done_cycle", cyc, e.due);
            chk("acc", int'(acc_o[i]), int'(e.acc));
            chk("carry", int'(carry_o[i]), int'(e.carry));
            chk("ovf_sticky", int'(ovf_o[i]), int'(e.ovf));
            chk("op_cnt", int'(cnt_o[i]), int'(e.cnt));
          end
        end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
          chk("done_missing", int'(done_o[i]), 1);
          void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic push(input logic [N-1:0] d, input logic s);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_sub = s;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (rdy_o[0]) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = N'($urandom); in_sub = 1'($urandom);
    chk("accept", int'(ok), 1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic chk_both_acc(input string name, input int a0, input int a1);
    chk({name, "_wrap"}, int'(acc_o[0]), a0);
    chk({name, "_sat"},  int'(acc_o[1]), a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals [3];
    int h0;
    vals = '{1, 2, 3};
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_data = '0;
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_acc", int'(acc_o[i]), 0);
      chk("rst_x", int'(x_o[i]), 0);
      chk("rst_y", int'(y_o[i]), 0);
      chk("rst_flags", int'({an_o[i], carry_o[i], ovf_o[i], done_o[i]}), 0);
      chk("rst_cnt", int'(cnt_o[i]), 0);
      chk("rst_ready", int'(rdy_o[i]), 1);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed arithmetic sequence.
    push(4'd5, 1'b0); settle();
    chk_both_acc("p5", 5, 5);
    chk("p5_done", int'(done_o[0]), 1);
    chk("p5_cnt", int'(cnt_o[0]), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done_o[0]), 0);
    push(4'd3, 1'b1); settle();
    chk_both_acc("m3", 2, 2);
    chk("m3_carry", int'(carry_o[0]), 1);
    chk("m3_ovf", int'(ovf_o[0]), 0);
    push(4'd3, 1'b0); settle();
    chk_both_acc("p3a", 5, 5);
    push(4'd3, 1'b0); settle();
    chk_both_acc("p3b", 8, 7);
    chk("p3b_ovf_wrap", int'(ovf_o[0]), 1);
    chk("p3b_ovf_sat", int'(ovf_o[1]), 1);
    clr_pulse();
    push(4'd8, 1'b0); settle();
    chk_both_acc("p8", 8, 8);
    push(4'd1, 1'b1); settle();
    chk_both_acc("min_sat", 7, 8);
    chk("min_ovf_sat", int'(ovf_o[1]), 1);

    // Back-to-back with in_valid held high.
    clr_pulse();
    h0 = hs_cnt;
    in_valid = 1'b1; in_data = 4'd1; in_sub = 1'b0;
    for (int i = 0, k = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_ready", int'(rdy_o[0]), (i % 2 == 0) ? 1 : 0);
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        k++;
        if (k < 3) in_data = N'(vals[k]);
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_accepts", hs_cnt - h0, 3);
    chk_both_acc("b2b", 6, 6);
    chk("b2b_cnt", int'(cnt_o[0]), 3);

    // clr during EXEC, then clr with in_valid in IDLE.
    clr_pulse();
    push(4'd5, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    chk_both_acc("clr_exec", 0, 0);
    chk("clr_exec_done", int'(done_o[0]), 0);
    chk("clr_exec_cnt", int'(cnt_o[0]), 0);
    @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b1; in_data = 4'd4;
    h0 = hs_cnt;
    @(negedge clk);
    chk("clr_ready", int'(rdy_o[0]), 0);
    @(posedge clk); #1; clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_no_accept", hs_cnt - h0, 0);
    chk("clr_idle_ready", int'(rdy_o[0]), 1);

    // Asynchronous reset in the middle of EXEC.
    push(4'd3, 1'b0); settle();
    chk_both_acc("pre_rst", 3, 3);
    push(4'd7, 1'b0);
    #2; rst_n = 1'b0; model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_acc", int'(acc_o[i]), 0);
      chk("arst_y", int'(y_o[i]), 0);
      chk("arst_cnt", int'(cnt_o[i]), 0);
      chk("arst_ready", int'(rdy_o[i]), 1);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_both_acc("arst_abort", 0, 0);
    chk("arst_done", int'(done_o[0]), 0);

    // Randomized operations with random clears.
    for (int it = 0; it < 80; it++) begin
      push(N'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) < 2) begin
        clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
      end
      if ($urandom_range(0, 9) < 1) clr_pulse();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Counter saturation.
    clr_pulse();
    for (int it = 0; it < 256; it++) push(N'($urandom), 1'($urandom));
    settle();
    chk("cnt_sat_wrap", int'(cnt_o[0]), 255);
    chk("cnt_sat_sat", int'(cnt_o[1]), 255);
    repeat (3) @(negedge clk);
    chk("queue_drained", q[0].size() + q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 Parameter: n, default 4, operand/accumulator width in bits (two's complement).
REQ-002 Parameter: SAT, default 0, 1 = saturate accumulator on signed overflow, 0 = wrap.
REQ-003 Ports: clk  in  1  rising-edge clock.
REQ-004 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: clr  in  1  synchronous clear of accumulator, flags and counter.
REQ-006 Ports: in_valid  in  1  operand available; in_ready  out  1  block accepts operand.
REQ-007 Ports: in_data  in  n  operand; in_sub  in  1  0 = add, 1 = subtract.
REQ-008 Ports: addsub_x  out  n, addsub_y  out  n, addsub_add_n  out  1  registered operands driven to the external combinational adder-subtractor.
REQ-009 Ports: addsub_s  in  n, addsub_c_out  in  1, addsub_over_flow  in  1  result returned by that adder-subtractor in the same cycle.
REQ-010 Ports: acc  out  n  accumulator; carry  out  1  c_out of last operation; ovf_sticky  out  1  sticky signed overflow; done  out  1  one-cycle completion pulse; op_cnt  out  8  completed-operation count.

Function
REQ-011 The FSM SHALL have two states: IDLE and EXEC.
REQ-012 in_ready SHALL equal (state==IDLE) and not clr, combinationally.
REQ-013 In IDLE, on in_valid and in_ready at a rising edge, the block SHALL latch addsub_x <= acc, addsub_y <= in_data, addsub_add_n <= in_sub, and enter EXEC.
REQ-014 In IDLE without a handshake, addsub_x/y/add_n SHALL hold their values.
REQ-015 In EXEC (one cycle, unconditional), the block SHALL sample addsub_s, addsub_c_out and addsub_over_flow at the next edge, update acc, carry, ovf_sticky and op_cnt, assert done for exactly the following cycle, and return to IDLE.
REQ-016 Latency: handshake edge E0 -> acc updated at edge E0+1; done high between E0+1 and E0+2; at most one operation per 2 cycles.
REQ-017 SAT=0: acc SHALL take addsub_s unchanged.
REQ-018 SAT=1 with addsub_over_flow=1: acc SHALL take signed max (0 followed by n-1 ones) if addsub_x[n-1]=0, else signed min (1 followed by n-1 zeros); without overflow acc takes addsub_s.
REQ-019 ovf_sticky SHALL be set by any completed operation with addsub_over_flow=1 and cleared only by clr or reset.
REQ-020 carry SHALL reflect addsub_c_out of the most recent completed operation.
REQ-021 op_cnt SHALL increment per completed operation and saturate at 255.
REQ-022 clr SHALL have highest priority in any state: next edge sets acc=0, carry=0, ovf_sticky=0, op_cnt=0, done=0, state IDLE; an operation in EXEC is discarded and not counted.
REQ-023 in_valid with clr high SHALL NOT be accepted (in_ready=0); source must hold in_valid.
REQ-024 in_valid during EXEC SHALL be ignored until IDLE; in_data/in_sub need only be stable in the handshake cycle.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, acc=0, addsub_x=0, addsub_y=0, addsub_add_n=0, carry=0, ovf_sticky=0, done=0, op_cnt=0, regardless of clk.
REQ-026 Reset asserted during EXEC SHALL abort the operation; after release the block is in IDLE with in_ready=1 (clr low).

Verification (n=4, external adder-subtractor connected)
REQ-027 Reset, push +5 add -> after 2 cycles acc=0101, done pulse 1 cycle, op_cnt=1, ovf_sticky=0.
REQ-028 acc=0101, push 3 sub -> acc=0010, carry=1, ovf_sticky=0; push 3 add then 3 add -> acc=0101 then 1000 with ovf_sticky=1 (SAT=0).
REQ-029 Same as REQ-028 with SAT=1 -> final acc=0111, ovf_sticky=1; from acc=1000, push 1 sub -> acc=1000 (saturate to min), ovf_sticky=1.
REQ-030 in_valid held high continuously with values 1,2,3 -> in_ready toggles 1/0, exactly three accepts in 6 cycles, acc=0110, op_cnt=3.
REQ-031 clr asserted in EXEC cycle -> next edge acc=0, flags 0, op_cnt unchanged at 0, no done pulse; clr with in_valid in IDLE -> in_ready=0, no accept.
REQ-032 rst_n pulsed low mid-EXEC between clock edges -> outputs zero immediately; 256 accepted operations -> op_cnt stays 255.
